// File: rtl/aes_axil_regs.sv
// AXI4-Lite register file for the AES-256 encrypt/decrypt cores: key/text
// word shifters, edge-triggered start pulses, done capture and popping result reads.
module aes_axil_regs #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [31:0] C_ID_VALUE         = 32'hAE52_0100
) (
  input  logic                          clk_in1,
  input  logic                          reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [255:0]                  enc_key,
  output logic [255:0]                  dec_key,
  output logic [127:0]                  enc_text,
  output logic [127:0]                  dec_text,
  output logic                          enc_start,
  output logic                          dec_start,
  input  logic                          enc_busy,
  input  logic                          dec_busy,
  input  logic                          enc_done,
  input  logic                          dec_done,
  input  logic [127:0]                  enc_result,
  input  logic [127:0]                  dec_result
);

  localparam logic [3:0] IDX_ID       = 4'h0;
  localparam logic [3:0] IDX_CTRL     = 4'h1;
  localparam logic [3:0] IDX_STATUS   = 4'h2;
  localparam logic [3:0] IDX_ENC_KEY  = 4'h4;
  localparam logic [3:0] IDX_DEC_KEY  = 4'h5;
  localparam logic [3:0] IDX_ENC_TEXT = 4'h6;
  localparam logic [3:0] IDX_DEC_TEXT = 4'h7;
  localparam logic [3:0] IDX_ENC_OUT  = 4'h8;
  localparam logic [3:0] IDX_DEC_OUT  = 4'h9;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [3:0] KEY_WORDS    = 4'd8;
  localparam logic [2:0] TXT_WORDS    = 3'd4;
  localparam logic [2:0] PTR_END      = 3'd4;

  logic        aw_cap, w_cap, aw_cap_n, w_cap_n, bvalid_n, rvalid_n;
  logic        aw_hs, w_hs, ar_hs, do_write, wr_full, wr_ok, rd_ok;
  logic [3:0]  wr_idx, wr_strb, rd_idx;
  logic [31:0] wr_data, rd_data, status;
  logic [1:0]  ctrl, ctrl_prev;
  logic [3:0]  enc_key_cnt, dec_key_cnt;
  logic [2:0]  enc_txt_cnt, dec_txt_cnt, enc_p, dec_p;
  logic        enc_valid, dec_valid, enc_err, dec_err;
  logic        enc_rise, dec_rise, enc_ok, dec_ok;
  logic [127:0] enc_res, dec_res;
  logic        unused_addr;

  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

  assign aw_hs    = s_axi_awvalid & s_axi_awready;
  assign w_hs     = s_axi_wvalid & s_axi_wready;
  assign ar_hs    = s_axi_arvalid & s_axi_arready;
  assign do_write = aw_cap & w_cap & ~s_axi_bvalid;
  assign wr_full  = (wr_strb == 4'hF);
  assign rd_idx   = s_axi_araddr[5:2];

  // Write decode: CTRL always answers OKAY, shifters only on full-word strobes
  always_comb begin
    wr_ok = 1'b0;
    case (wr_idx)
      IDX_CTRL:                                            wr_ok = 1'b1;
      IDX_ENC_KEY, IDX_DEC_KEY, IDX_ENC_TEXT, IDX_DEC_TEXT: wr_ok = wr_full;
      default:                                             wr_ok = 1'b0;
    endcase
  end

  always_comb begin
    aw_cap_n = aw_cap;
    w_cap_n  = w_cap;
    bvalid_n = s_axi_bvalid;
    rvalid_n = s_axi_rvalid;
    if (aw_hs) aw_cap_n = 1'b1;
    if (w_hs)  w_cap_n  = 1'b1;
    if (do_write) begin
      aw_cap_n = 1'b0;
      w_cap_n  = 1'b0;
      bvalid_n = 1'b1;
    end else if (s_axi_bvalid && s_axi_bready) begin
      bvalid_n = 1'b0;
    end
    if (ar_hs) rvalid_n = 1'b1;
    else if (s_axi_rvalid && s_axi_rready) rvalid_n = 1'b0;
  end

  // Write address/data capture and response
  always_ff @(posedge clk_in1 or negedge reset) begin
    if (!reset) begin
      aw_cap        <= 1'b0;
      w_cap         <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      wr_idx        <= 4'h0;
      wr_data       <= 32'h0;
      wr_strb       <= 4'h0;
    end else begin
      aw_cap        <= aw_cap_n;
      w_cap         <= w_cap_n;
      s_axi_bvalid  <= bvalid_n;
      s_axi_awready <= ~aw_cap_n & ~bvalid_n;
      s_axi_wready  <= ~w_cap_n & ~bvalid_n;
      if (aw_hs) wr_idx <= s_axi_awaddr[5:2];
      if (w_hs) begin
        wr_data <= s_axi_wdata;
        wr_strb <= s_axi_wstrb;
      end
      if (do_write) s_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign enc_rise = ctrl[0] & ~ctrl_prev[0];
  assign dec_rise = ctrl[1] & ~ctrl_prev[1];
  assign enc_ok   = (enc_key_cnt == KEY_WORDS) && (enc_txt_cnt == TXT_WORDS) && !enc_busy;
  assign dec_ok   = (dec_key_cnt == KEY_WORDS) && (dec_txt_cnt == TXT_WORDS) && !dec_busy;

  // Control, buffers, start rules and result capture
  always_ff @(posedge clk_in1 or negedge reset) begin
    if (!reset) begin
      ctrl        <= 2'b00;
      ctrl_prev   <= 2'b00;
      enc_key     <= '0;
      dec_key     <= '0;
      enc_text    <= '0;
      dec_text    <= '0;
      enc_key_cnt <= 4'd0;
      dec_key_cnt <= 4'd0;
      enc_txt_cnt <= 3'd0;
      dec_txt_cnt <= 3'd0;
      enc_valid   <= 1'b0;
      dec_valid   <= 1'b0;
      enc_err     <= 1'b0;
      dec_err     <= 1'b0;
      enc_start   <= 1'b0;
      dec_start   <= 1'b0;
      enc_res     <= '0;
      dec_res     <= '0;
    end else begin
      ctrl_prev <= ctrl;
      if (do_write && wr_idx == IDX_CTRL && wr_strb[0]) ctrl <= wr_data[1:0];
      if (do_write && wr_full && wr_idx == IDX_ENC_KEY) begin
        enc_key <= {enc_key[223:0], wr_data};
        if (enc_key_cnt != KEY_WORDS) enc_key_cnt <= enc_key_cnt + 4'd1;
      end
      if (do_write && wr_full && wr_idx == IDX_DEC_KEY) begin
        dec_key <= {dec_key[223:0], wr_data};
        if (dec_key_cnt != KEY_WORDS) dec_key_cnt <= dec_key_cnt + 4'd1;
      end
      if (do_write && wr_full && wr_idx == IDX_ENC_TEXT) begin
        enc_text <= {enc_text[95:0], wr_data};
        if (enc_txt_cnt != TXT_WORDS) enc_txt_cnt <= enc_txt_cnt + 3'd1;
      end
      if (do_write && wr_full && wr_idx == IDX_DEC_TEXT) begin
        dec_text <= {dec_text[95:0], wr_data};
        if (dec_txt_cnt != TXT_WORDS) dec_txt_cnt <= dec_txt_cnt + 3'd1;
      end
      enc_start <= enc_rise & enc_ok;
      dec_start <= dec_rise & dec_ok;
      if (enc_rise) begin
        if (enc_ok) begin
          enc_key_cnt <= 4'd0;
          enc_txt_cnt <= 3'd0;
          enc_valid   <= 1'b0;
          enc_err     <= 1'b0;
        end else begin
          enc_err <= 1'b1;
        end
      end
      if (dec_rise) begin
        if (dec_ok) begin
          dec_key_cnt <= 4'd0;
          dec_txt_cnt <= 3'd0;
          dec_valid   <= 1'b0;
          dec_err     <= 1'b0;
        end else begin
          dec_err <= 1'b1;
        end
      end
      if (enc_done) begin
        enc_res   <= enc_result;
        enc_valid <= 1'b1;
      end
      if (dec_done) begin
        dec_res   <= dec_result;
        dec_valid <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] out_word(input logic [127:0] res, input logic [2:0] p);
    case (p)
      3'd0:    out_word = res[127:96];
      3'd1:    out_word = res[95:64];
      3'd2:    out_word = res[63:32];
      3'd3:    out_word = res[31:0];
      default: out_word = 32'h0;
    endcase
  endfunction

  assign status = {9'd0, dec_txt_cnt, 1'b0, enc_txt_cnt, dec_key_cnt, enc_key_cnt,
                   2'b00, dec_err, enc_err, dec_valid, enc_valid, dec_busy, enc_busy};

  always_comb begin
    rd_ok   = 1'b1;
    rd_data = 32'h0;
    case (rd_idx)
      IDX_ID:      rd_data = C_ID_VALUE;
      IDX_CTRL:    rd_data = {30'd0, ctrl};
      IDX_STATUS:  rd_data = status;
      IDX_ENC_OUT: rd_data = out_word(enc_res, enc_p);
      IDX_DEC_OUT: rd_data = out_word(dec_res, dec_p);
      default:     rd_ok   = 1'b0;
    endcase
  end

  // Read channel; a done pulse overrides a coincident pop and rewinds the pointer
  always_ff @(posedge clk_in1 or negedge reset) begin
    if (!reset) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= 32'h0;
      s_axi_rresp   <= RESP_OKAY;
      enc_p         <= PTR_END;
      dec_p         <= PTR_END;
    end else begin
      s_axi_rvalid  <= rvalid_n;
      s_axi_arready <= ~rvalid_n;
      if (ar_hs) begin
        s_axi_rdata <= rd_data;
        s_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        if (rd_idx == IDX_ENC_OUT && enc_p != PTR_END) enc_p <= enc_p + 3'd1;
        if (rd_idx == IDX_DEC_OUT && dec_p != PTR_END) dec_p <= dec_p + 3'd1;
      end
      if (enc_done) enc_p <= 3'd0;
      if (dec_done) dec_p <= 3'd0;
    end
  end

endmodule

// File: tb/tb_aes_axil_regs.sv
// Directed bench for aes_axil_regs: table of register accesses plus hand-built
// sequences for start rules, popping reads, handshake stalls and async reset.
module tb_aes_axil_regs;

  logic         clk_in1 = 1'b0;
  logic         reset;
  logic [5:0]   s_axi_awaddr, s_axi_araddr;
  logic         s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0]  s_axi_wdata, s_axi_rdata;
  logic [3:0]   s_axi_wstrb;
  logic [1:0]   s_axi_bresp, s_axi_rresp;
  logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic         s_axi_rvalid, s_axi_rready;
  logic [255:0] enc_key, dec_key;
  logic [127:0] enc_text, dec_text, enc_result, dec_result;
  logic         enc_start, dec_start, enc_busy, dec_busy, enc_done, dec_done;

  always #5 clk_in1 = ~clk_in1;

  aes_axil_regs dut (
    .clk_in1(clk_in1), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .enc_key(enc_key), .dec_key(dec_key), .enc_text(enc_text), .dec_text(dec_text),
    .enc_start(enc_start), .dec_start(dec_start), .enc_busy(enc_busy), .dec_busy(dec_busy),
    .enc_done(enc_done), .dec_done(dec_done), .enc_result(enc_result), .dec_result(dec_result)
  );

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  localparam logic [255:0] KEY_EXP  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] TEXT_EXP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [31:0]  ID_EXP   = 32'hAE52_0100;

  vec_t tbl[$];
  int   checks = 0, failures = 0;
  int   enc_starts = 0, dec_starts = 0, b_rises = 0;
  logic bv_q = 1'b0;

  always @(posedge clk_in1) begin
    if (enc_start) enc_starts++;
    if (dec_start) dec_starts++;
    if (s_axi_bvalid && !bv_q) b_rises++;
    bv_q <= s_axi_bvalid;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  function automatic void chk_w(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %064h expected %064h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: handshake timed out", name);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in1);
  endtask

  task automatic add(input logic wr, input logic [5:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] r, input logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = rd;
    tbl.push_back(v);
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_go, w_go, got;
    int n;
    aw_done = 0; w_done = 0; got = 0; n = 0; resp = 2'b11;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_go = s_axi_awvalid && s_axi_awready;
      w_go  = s_axi_wvalid && s_axi_wready;
      @(negedge clk_in1); n++;
      if (aw_go) begin s_axi_awvalid = 1'b0; aw_done = 1; end
      if (w_go)  begin s_axi_wvalid  = 1'b0; w_done  = 1; end
    end
    while (!got && n < 100) begin
      if (s_axi_bvalid) begin resp = s_axi_bresp; got = 1; end
      @(negedge clk_in1); n++;
    end
    s_axi_bready = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    if (!got) timeout($sformatf("wr_%02h", a));
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    bit done;
    int n;
    d = 32'h0; r = 2'b11; done = 0; n = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!done && n < 50) begin
      done = s_axi_arready;
      @(negedge clk_in1); n++;
    end
    s_axi_arvalid = 1'b0;
    if (!done) begin
      timeout($sformatf("rd_addr_%02h", a));
    end else begin
      done = 0;
      s_axi_rready = 1'b1;
      while (!done && n < 100) begin
        if (s_axi_rvalid) begin d = s_axi_rdata; r = s_axi_rresp; done = 1; end
        @(negedge clk_in1); n++;
      end
      s_axi_rready = 1'b0;
      if (!done) timeout($sformatf("rd_data_%02h", a));
    end
  endtask

  task automatic wr_ok(input string name, input logic [5:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 4'hF, r);
    chk(name, 32'(r), 32'h0);
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    chk({name, "_resp"}, 32'(r), 32'h0);
    chk(name, d, exp);
  endtask

  logic [31:0] key_words[8];
  logic [31:0] txt_words[4];
  logic [31:0] rd;
  logic [1:0]  rr;
  int          b0, s0, n;
  bit          got;

  initial begin
    key_words = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                  32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f};
    txt_words = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    reset = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; enc_busy = 1'b0; dec_busy = 1'b0; enc_done = 1'b0; dec_done = 1'b0;
    enc_result = '0; dec_result = '0;
    tick(3);
    chk("rst_handshakes", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                               s_axi_rvalid, enc_start, dec_start}), 32'h0);
    chk("rst_rdata", s_axi_rdata, 32'h0);
    chk_w("rst_enc_key", enc_key, '0);
    reset = 1'b1;
    tick(2);

    // Register-access table
    add(0, 6'h00, 0, 4'hF, 2'b00, ID_EXP);
    add(0, 6'h08, 0, 4'hF, 2'b00, 32'h0);
    add(0, 6'h3C, 0, 4'hF, 2'b10, 32'h0);
    add(0, 6'h10, 0, 4'hF, 2'b10, 32'h0);
    add(0, 6'h20, 0, 4'hF, 2'b00, 32'h0);
    add(1, 6'h00, 32'h1234, 4'hF, 2'b10, 0);
    add(1, 6'h08, 32'h1234, 4'hF, 2'b10, 0);
    for (int i = 0; i < 8; i++) add(1, 6'h10, key_words[i], 4'hF, 2'b00, 0);
    add(1, 6'h18, 32'hdeadbeef, 4'h3, 2'b10, 0);
    for (int i = 0; i < 4; i++) add(1, 6'h18, txt_words[i], 4'hF, 2'b00, 0);
    add(0, 6'h08, 0, 4'hF, 2'b00, 32'h0004_0800);
    add(0, 6'h04, 0, 4'hF, 2'b00, 32'h0);
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, rr);
        chk($sformatf("vec%0d_bresp", i), 32'(rr), 32'(tbl[i].resp));
      end else begin
        axi_read(tbl[i].addr, rd, rr);
        chk($sformatf("vec%0d_rresp", i), 32'(rr), 32'(tbl[i].resp));
        chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
      end
    end

    // Accepted encrypt start
    wr_ok("ctrl_enc_1", 6'h04, 32'h1);
    tick(3);
    wr_ok("ctrl_enc_0", 6'h04, 32'h0);
    tick(3);
    chk("enc_start_pulses", 32'(enc_starts), 32'd1);
    chk("dec_start_none", 32'(dec_starts), 32'd0);
    chk_w("enc_key_val", enc_key, KEY_EXP);
    chk_w("enc_text_val", 256'(enc_text), 256'(TEXT_EXP));
    rd_chk("status_after_start", 6'h08, 32'h0);

    // Result capture and popping reads
    enc_result = 128'h8ea2b7ca516745bfeafc49904b496089;
    enc_done = 1'b1;
    tick(1);
    enc_done = 1'b0;
    rd_chk("enc_out0", 6'h20, 32'h8ea2b7ca);
    rd_chk("enc_out1", 6'h20, 32'h516745bf);
    rd_chk("enc_out2", 6'h20, 32'heafc4990);
    rd_chk("enc_out3", 6'h20, 32'h4b496089);
    rd_chk("enc_out4", 6'h20, 32'h0);
    rd_chk("status_enc_valid", 6'h08, 32'h0000_0004);

    // Rejected encrypt start: only three key words
    for (int i = 0; i < 3; i++) wr_ok("enc_key3", 6'h10, key_words[i]);
    wr_ok("ctrl_rej_1", 6'h04, 32'h1);
    tick(3);
    chk("enc_start_rejected", 32'(enc_starts), 32'd1);
    rd_chk("status_enc_err", 6'h08, 32'h0000_0314);
    wr_ok("ctrl_rej_0", 6'h04, 32'h0);

    // Decrypt start refused while busy, then accepted
    for (int i = 0; i < 8; i++) wr_ok("dec_key_wr", 6'h14, key_words[i]);
    for (int i = 0; i < 4; i++) wr_ok("dec_txt_wr", 6'h1C, txt_words[i]);
    dec_busy = 1'b1;
    wr_ok("ctrl_dec_busy", 6'h04, 32'h2);
    tick(3);
    chk("dec_start_busy", 32'(dec_starts), 32'd0);
    rd_chk("status_dec_err", 6'h08, 32'h0040_8336);
    wr_ok("ctrl_dec_0", 6'h04, 32'h0);
    dec_busy = 1'b0;
    wr_ok("ctrl_dec_2", 6'h04, 32'h2);
    tick(3);
    chk("dec_start_pulses", 32'(dec_starts), 32'd1);
    rd_chk("status_dec_ok", 6'h08, 32'h0000_0314);
    chk_w("dec_key_val", dec_key, KEY_EXP);

    // CTRL byte lanes: lane 0 disabled leaves the register alone
    axi_write(6'h04, 32'h0, 4'hE, rr);
    chk("ctrl_lane_resp", 32'(rr), 32'h0);
    rd_chk("ctrl_lane_keep", 6'h04, 32'h2);
    wr_ok("ctrl_clear", 6'h04, 32'h0);

    // Done coinciding with a pop
    dec_result = 128'h0123456789abcdef_fedcba9876543210;
    dec_done = 1'b1;
    tick(1);
    dec_done = 1'b0;
    rd_chk("dec_out0", 6'h24, 32'h01234567);
    chk("coinc_arready", 32'(s_axi_arready), 32'h1);
    s_axi_araddr = 6'h24; s_axi_arvalid = 1'b1;
    dec_result = 128'hcafef00d_deadbeef_0badc0de_12345678;
    dec_done = 1'b1;
    tick(1);
    s_axi_arvalid = 1'b0; dec_done = 1'b0; s_axi_rready = 1'b1;
    got = 0; n = 0;
    while (!got && n < 10) begin
      if (s_axi_rvalid) begin rd = s_axi_rdata; got = 1; end
      tick(1); n++;
    end
    s_axi_rready = 1'b0;
    if (!got) timeout("coinc_read");
    else chk("coinc_pre_capture", rd, 32'h89abcdef);
    rd_chk("coinc_new_word0", 6'h24, 32'hcafef00d);
    rd_chk("status_dec_valid", 6'h08, 32'h0000_031C);

    // W presented three cycles ahead of AW, then a long bready stall
    b0 = b_rises;
    s_axi_wdata = 32'h0badf00d; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    chk("wfirst_wready", 32'(s_axi_wready), 32'h1);
    tick(1);
    s_axi_wvalid = 1'b0;
    chk("wfirst_wcaptured", 32'(s_axi_wready), 32'h0);
    tick(2);
    s_axi_awaddr = 6'h1C; s_axi_awvalid = 1'b1;
    chk("wfirst_awready", 32'(s_axi_awready), 32'h1);
    tick(1);
    s_axi_awvalid = 1'b0;
    tick(1);
    chk("wfirst_bresp", 32'({s_axi_bvalid, s_axi_bresp}), 32'h4);
    for (int i = 0; i < 5; i++) begin
      s_axi_awaddr = 6'h1C; s_axi_wdata = 32'hffffffff;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      chk($sformatf("stall_bvalid%0d", i), 32'(s_axi_bvalid), 32'h1);
      chk($sformatf("stall_no_accept%0d", i), 32'({s_axi_awready, s_axi_wready}), 32'h0);
      tick(1);
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    tick(1);
    s_axi_bready = 1'b0;
    chk("stall_bvalid_drop", 32'(s_axi_bvalid), 32'h0);
    chk("stall_one_response", 32'(b_rises - b0), 32'd1);
    rd_chk("status_one_text", 6'h08, 32'h0010_031C);

    // rready stall keeps rdata stable
    s_axi_araddr = 6'h00; s_axi_arvalid = 1'b1;
    chk("rstall_arready", 32'(s_axi_arready), 32'h1);
    tick(1);
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rstall_hold%0d", i), 32'({s_axi_rvalid, s_axi_arready}), 32'h2);
      chk($sformatf("rstall_rdata%0d", i), s_axi_rdata, ID_EXP);
      tick(1);
    end
    s_axi_rready = 1'b1;
    tick(1);
    s_axi_rready = 1'b0;
    chk("rstall_release", 32'({s_axi_rvalid, s_axi_arready}), 32'h1);

    // Reset in the middle of an AW-only capture
    s0 = b_rises;
    s_axi_awaddr = 6'h10; s_axi_awvalid = 1'b1;
    chk("rstmid_awready", 32'(s_axi_awready), 32'h1);
    tick(1);
    s_axi_awvalid = 1'b0;
    chk("rstmid_aw_only", 32'({s_axi_awready, s_axi_wready}), 32'h1);
    #2 reset = 1'b0;
    #1 chk("rstmid_drop", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready}), 32'h0);
    tick(2);
    reset = 1'b1;
    tick(5);
    chk("rstmid_no_resp", 32'(b_rises - s0), 32'd0);
    chk_w("rstmid_key_cleared", enc_key, '0);
    rd_chk("rstmid_status", 6'h08, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
